sipo_deserializer: RTL and testbench

- Serial-in/parallel-out receiver. It is the capture end of the LSB-first serial word link driven by the team's parallel-in/serial-out shifter.
- Collects NUM_WORDS words of M bits each, one bit per qualified cycle, into a shift register.
- Hands each completed word to a single-entry output holding register with a valid/ready handshake.
- Sits between the ELM serial datapath (shift-add multiplier operand/result streams) and word-wide consumers such as accumulators and hidden-layer buffers.

---
 rtl/sipo_deserializer_pkg.sv | 12 +
 rtl/sipo_deserializer_shift_reg.sv | 26 ++
 rtl/sipo_deserializer.sv | 130 +++++++++++++
 tb/tb_sipo_deserializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deserializer_pkg.sv
// Shared constants and state encoding for the serial word link receiver.
// The word width is shared with the PISO shifter and the shift-add multiplier.
package sipo_deserializer_pkg;

  localparam int SIPO_WORD_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sipo_state_e;

endpackage

// File: rtl/sipo_deserializer_shift_reg.sv
// M-bit LSB-first capture register: each enabled cycle shifts serial_i into the MSB.
// This is the receive-side mirror of the PISO core.
module sipo_deserializer_shift_reg #(
  parameter int M = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         shift_en_i,
  input  logic         serial_i,
  output logic [M-1:0] sreg_o
);

  logic [M-1:0] sreg_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sreg_q <= '0;
    end else if (shift_en_i) begin
      sreg_q <= {serial_i, sreg_q[M-1:1]};
    end
  end

  assign sreg_o = sreg_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: collects num_words_i words of M bits (LSB first)
// and hands each completed word to a single-entry valid/ready holding register.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int M  = SIPO_WORD_W,
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] num_words_i,
  input  logic          serial_in_i,
  input  logic          serial_valid_i,
  output logic [M-1:0]  data_out_o,
  output logic          data_valid_o,
  input  logic          data_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          overrun_o
);

  localparam int BW = $clog2(M);

  sipo_state_e   state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [CW-1:0] num_words_q, num_words_d;
  logic [M-1:0]  data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic          shift_clr, shift_en;
  logic [M-1:0]  sreg;
  logic [M-1:0]  word_c;

  sipo_deserializer_shift_reg #(.M(M)) u_shift_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (shift_clr),
    .shift_en_i (shift_en),
    .serial_i   (serial_in_i),
    .sreg_o     (sreg)
  );

  // Word as it will look after the bit arriving this cycle is shifted in.
  assign word_c = {serial_in_i, sreg[M-1:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      num_words_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      num_words_q  <= num_words_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    num_words_d  = num_words_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    shift_clr    = 1'b0;
    shift_en     = 1'b0;

    if (data_valid_q && data_ready_i) begin
      data_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i && (num_words_i != '0)) begin
          state_d     = ST_SHIFT;
          num_words_d = num_words_i;
          bit_cnt_d   = '0;
          word_cnt_d  = '0;
          overrun_d   = 1'b0;
          shift_clr   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (serial_valid_i) begin
          shift_en = 1'b1;
          if (bit_cnt_q == BW'(M-1)) begin
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            // A consume in the completion cycle frees the slot for the new word.
            if (!data_valid_q || data_ready_i) begin
              data_out_d   = word_c;
              data_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            if (word_cnt_d == num_words_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = (state_q == ST_SHIFT);
  assign done_o       = done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer against a word-level
// reference model that assembles words by bit position.
module tb_sipo_deserializer;

  localparam int M  = 16;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [CW-1:0] num_words_i = '0;
  logic          serial_in_i = 1'b0;
  logic          serial_valid_i = 1'b0;
  logic          data_ready_i = 1'b0;
  logic [M-1:0]  data_out_o;
  logic          data_valid_o, busy_o, done_o, overrun_o;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit          m_busy, m_dv, m_done, m_ovr;
  int          m_cnt, m_words, m_nw;
  int unsigned m_acc, m_dout;

  sipo_deserializer #(.M(M), .CW(CW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .num_words_i    (num_words_i),
    .serial_in_i    (serial_in_i),
    .serial_valid_i (serial_valid_i),
    .data_out_o     (data_out_o),
    .data_valid_o   (data_valid_o),
    .data_ready_i   (data_ready_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance the model with the current inputs, then let the DUT take the same edge.
  task automatic tick();
    if (rst_i) begin
      m_busy = 0; m_dv = 0; m_done = 0; m_ovr = 0;
      m_cnt = 0; m_words = 0; m_nw = 0; m_acc = 0; m_dout = 0;
    end else begin
      m_done = 0;
      if (m_dv && data_ready_i) m_dv = 0;
      if (!m_busy) begin
        if (start_i && num_words_i != 0) begin
          m_busy = 1; m_nw = int'(num_words_i);
          m_cnt = 0; m_acc = 0; m_words = 0; m_ovr = 0;
        end
      end else if (serial_valid_i) begin
        m_acc = m_acc + (int'(serial_in_i) << m_cnt);
        m_cnt++;
        if (m_cnt == M) begin
          if (!m_dv || data_ready_i || !(m_dv)) begin
            if (!m_dv) begin m_dout = m_acc; m_dv = 1; end
            else m_ovr = 1;
          end else m_ovr = 1;
          m_words++; m_cnt = 0; m_acc = 0;
          if (m_words == m_nw) begin m_busy = 0; m_done = 1; end
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [M-1:0] w, input bit gaps, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (gaps) begin
        serial_valid_i = 1'b0; serial_in_i = ~w[i];
        tick();
      end
      serial_valid_i = 1'b1; serial_in_i = w[i];
      tick();
    end
    serial_valid_i = 1'b0;
  endtask

  task automatic start_frame(input int nw);
    start_i = 1'b1; num_words_i = CW'(nw);
    serial_valid_i = 1'b1; serial_in_i = 1'b1;
    tick();
    start_i = 1'b0; serial_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    n_checks++;
    if ({data_out_o, data_valid_o, busy_o, done_o, overrun_o} !== {16'h0, 4'b0000})
      $display("FAIL reset: got dout=%h dv=%b busy=%b done=%b ovr=%b, want all 0",
               data_out_o, data_valid_o, busy_o, done_o, overrun_o);
    else n_pass++;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    data_ready_i = 1'b0;
    start_frame(1);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL single_busy: got %b want 1", busy_o); else n_pass++;
    send_word(16'hA5C3, 0, 15);
    n_checks++;
    if (data_valid_o !== 1'b0) $display("FAIL single_early: dv got %b want 0", data_valid_o); else n_pass++;
    send_word(16'hA5C3 >> 15, 0, 1);
    n_checks++;
    if ({data_out_o, data_valid_o, done_o, busy_o} !== {16'hA5C3, 3'b110})
      $display("FAIL single_word: got dout=%h dv=%b done=%b busy=%b want a5c3 1 1 0",
               data_out_o, data_valid_o, done_o, busy_o);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if ({data_valid_o, done_o} !== 2'b10)
      $display("FAIL single_hold: got dv=%b done=%b want 1 0", data_valid_o, done_o);
    else n_pass++;
    data_ready_i = 1'b1;
    tick();
    data_ready_i = 1'b0;
    n_checks++;
    if ({data_out_o, data_valid_o} !== {16'hA5C3, 1'b0})
      $display("FAIL single_consume: got dout=%h dv=%b want a5c3 0", data_out_o, data_valid_o);
    else n_pass++;
  endtask

  task automatic test_gapped();
    start_frame(1);
    send_word(16'hA5C3, 1, 15);
    n_checks++;
    if ({data_valid_o, busy_o} !== 2'b01)
      $display("FAIL gapped_15: got dv=%b busy=%b want 0 1", data_valid_o, busy_o);
    else n_pass++;
    send_word(16'h0001, 1, 1);
    n_checks++;
    if ({data_out_o, data_valid_o, done_o} !== {16'hA5C3, 2'b11})
      $display("FAIL gapped_word: got dout=%h dv=%b done=%b want a5c3 1 1",
               data_out_o, data_valid_o, done_o);
    else n_pass++;
    data_ready_i = 1'b1; tick(); data_ready_i = 1'b0;
  endtask

  task automatic test_stream();
    logic [M-1:0] words [3];
    words = '{16'h1111, 16'h2222, 16'h3333};
    data_ready_i = 1'b1;
    start_frame(3);
    for (int k = 0; k < 3; k++) begin
      send_word(words[k], 0, M);
      n_checks++;
      if ({data_out_o, data_valid_o, overrun_o, done_o} !== {words[k], 2'b10, (k == 2)})
        $display("FAIL stream_w%0d: got dout=%h dv=%b ovr=%b done=%b want %h 1 0 %0d",
                 k, data_out_o, data_valid_o, overrun_o, done_o, words[k], k == 2);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_overrun();
    data_ready_i = 1'b0;
    start_frame(3);
    send_word(16'h1111, 0, M);
    n_checks++;
    if (overrun_o !== 1'b0) $display("FAIL ovr_w1: got %b want 0", overrun_o); else n_pass++;
    send_word(16'h2222, 0, M);
    n_checks++;
    if ({data_out_o, overrun_o} !== {16'h1111, 1'b1})
      $display("FAIL ovr_w2: got dout=%h ovr=%b want 1111 1", data_out_o, overrun_o);
    else n_pass++;
    send_word(16'h3333, 0, M);
    n_checks++;
    if ({data_out_o, data_valid_o, overrun_o, done_o, busy_o} !== {16'h1111, 4'b1110})
      $display("FAIL ovr_w3: got dout=%h dv=%b ovr=%b done=%b busy=%b want 1111 1 1 1 0",
               data_out_o, data_valid_o, overrun_o, done_o, busy_o);
    else n_pass++;
    start_frame(0);
    n_checks++;
    if ({overrun_o, busy_o} !== 2'b10)
      $display("FAIL ovr_nw0: got ovr=%b busy=%b want 1 0", overrun_o, busy_o);
    else n_pass++;
    data_ready_i = 1'b1; tick(); data_ready_i = 1'b0;
    start_frame(1);
    n_checks++;
    if (overrun_o !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun_o); else n_pass++;
    send_word(16'h0, 0, M);
    data_ready_i = 1'b1; tick(); data_ready_i = 1'b0;
  endtask

  task automatic test_simul();
    data_ready_i = 1'b0;
    start_frame(2);
    send_word(16'h1111, 0, M);
    send_word(16'h2222, 0, M - 1);
    data_ready_i = 1'b1;
    send_word(16'h2222 >> (M - 1), 0, 1);
    data_ready_i = 1'b0;
    n_checks++;
    if ({data_out_o, data_valid_o, overrun_o} !== {16'h2222, 2'b10})
      $display("FAIL simul: got dout=%h dv=%b ovr=%b want 2222 1 0",
               data_out_o, data_valid_o, overrun_o);
    else n_pass++;
    data_ready_i = 1'b1; tick(); data_ready_i = 1'b0;
  endtask

  task automatic test_edges();
    start_frame(1);
    send_word(16'hFFFF, 0, 7);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    n_checks++;
    if ({data_out_o, data_valid_o, busy_o, done_o, overrun_o} !== {16'h0, 4'b0000})
      $display("FAIL edge_rst: got dout=%h dv=%b busy=%b done=%b ovr=%b want all 0",
               data_out_o, data_valid_o, busy_o, done_o, overrun_o);
    else n_pass++;
    start_frame(0);
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL edge_nw0: busy got %b want 0", busy_o); else n_pass++;
    start_frame(1);
    send_word(16'hBEEF, 0, 5);
    start_i = 1'b1; num_words_i = 8'd5; tick(); start_i = 1'b0;
    send_word(16'hBEEF >> 5, 0, M - 5);
    n_checks++;
    if ({data_out_o, data_valid_o, done_o, busy_o} !== {16'hBEEF, 3'b110})
      $display("FAIL edge_beef: got dout=%h dv=%b done=%b busy=%b want beef 1 1 0",
               data_out_o, data_valid_o, done_o, busy_o);
    else n_pass++;
    data_ready_i = 1'b1; tick(); data_ready_i = 1'b0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      start_i = 1'b1; num_words_i = CW'($urandom_range(0, 4));
      tick();
      start_i = 1'b0;
      for (int c = 0; c < 90; c++) begin
        start_i        = ($urandom_range(0, 15) == 0);
        num_words_i    = CW'($urandom_range(0, 3));
        serial_valid_i = ($urandom_range(0, 3) != 0);
        serial_in_i    = 1'($urandom);
        data_ready_i   = ($urandom_range(0, 2) == 0);
        rst_i          = ($urandom_range(0, 199) == 0);
        tick();
        n_checks++;
        if ({data_out_o, data_valid_o, busy_o, done_o, overrun_o} !==
            {m_dout[M-1:0], m_dv, m_busy, m_done, m_ovr})
          $display("FAIL random f%0d c%0d: got dout=%h dv=%b busy=%b done=%b ovr=%b want %h %b %b %b %b",
                   f, c, data_out_o, data_valid_o, busy_o, done_o, overrun_o,
                   m_dout[M-1:0], m_dv, m_busy, m_done, m_ovr);
        else n_pass++;
      end
    end
    rst_i = 1'b0; start_i = 1'b0; serial_valid_i = 1'b0; data_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_gapped();
    test_stream();
    test_overrun();
    test_simul();
    test_edges();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
